// File: rtl/sdram_probe_seq.sv
// Sizes the attached SDRAM by signature write/readback, zero-fills the detected range,
// then hands the controller command port to a single host requester.
module sdram_probe_seq #(
    parameter int          ADDR_W    = 27,
    parameter bit          CLEAR_EN  = 1'b1,
    parameter logic [15:0] SIG0      = 16'd1032,
    parameter logic [15:0] SIG1      = 16'd2064,
    parameter logic [15:0] SIG2      = 16'd3128,
    parameter logic [15:0] SIG_ALIAS = 16'd12345
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    output logic              mem_we,
    output logic              mem_rd,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_din,
    input  logic              host_we,
    input  logic              host_req,
    output logic              host_ack,
    output logic [15:0]       host_dout,
    output logic [15:0]       cfg,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] A_SIG2  = ADDR_W'(28'h4000000);
    localparam logic [ADDR_W-1:0] A_SIG1  = ADDR_W'(28'h2000000);
    localparam logic [ADDR_W-1:0] A_SIG0  = ADDR_W'(28'h0000000);
    localparam logic [ADDR_W-1:0] A_ALIAS = ADDR_W'(28'h1000000);

    typedef enum logic [2:0] {
        S_WAIT_INIT, S_ISSUE, S_HOLD, S_WAIT, S_DECIDE, S_CLEAR, S_SERVE
    } state_t;

    // Probe ops are ordered so the next probe step is simply op+1.
    typedef enum logic [3:0] {
        OP_W2, OP_W1, OP_W0, OP_WA, OP_R2, OP_R1, OP_R0, OP_FILL, OP_HOST
    } op_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [15:0]       din;
    } cmd_t;

    state_t            state, state_nxt;
    op_t               op, l_op;
    cmd_t              l_cmd;
    logic              launch;
    logic              cmd_we;
    logic [2:0]        match;
    logic [27:0]       ptr;
    logic [27:0]       fill_limit;
    logic              pend_vld;
    logic              pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [15:0]       pend_din;

    function automatic cmd_t probe_cmd(input op_t o);
        case (o)
            OP_W2:   return '{we: 1'b1, addr: A_SIG2,  din: SIG2};
            OP_W1:   return '{we: 1'b1, addr: A_SIG1,  din: SIG1};
            OP_W0:   return '{we: 1'b1, addr: A_SIG0,  din: SIG0};
            OP_WA:   return '{we: 1'b1, addr: A_ALIAS, din: SIG_ALIAS};
            OP_R2:   return '{we: 1'b0, addr: A_SIG2,  din: 16'h0};
            OP_R1:   return '{we: 1'b0, addr: A_SIG1,  din: 16'h0};
            OP_R0:   return '{we: 1'b0, addr: A_SIG0,  din: 16'h0};
            default: return '{we: 1'b0, addr: '0,      din: 16'h0};
        endcase
    endfunction

    assign fill_limit = cfg[2] ? 28'h8000000 : (cfg[1] ? 28'h4000000 : 28'h2000000);

    assign mem_we = (state == S_ISSUE) &&  cmd_we;
    assign mem_rd = (state == S_ISSUE) && !cmd_we;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        l_op      = op;
        l_cmd     = '0;
        case (state)
            S_WAIT_INIT: begin
                if (mem_ready) begin
                    launch = 1'b1;
                    l_op   = OP_W2;
                    l_cmd  = probe_cmd(OP_W2);
                end
            end
            S_ISSUE: state_nxt = S_HOLD;
            // The controller may not drop ready until a cycle after the strobe.
            S_HOLD:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (mem_ready) begin
                    case (op)
                        OP_W2, OP_W1, OP_W0, OP_WA, OP_R2, OP_R1: begin
                            launch = 1'b1;
                            l_op   = op_t'(op + 4'd1);
                            l_cmd  = probe_cmd(l_op);
                        end
                        OP_R0:   state_nxt = S_DECIDE;
                        OP_FILL: state_nxt = S_CLEAR;
                        default: state_nxt = busy ? S_CLEAR : S_SERVE;
                    endcase
                end
            end
            S_DECIDE: state_nxt = (!match[0] || !CLEAR_EN) ? S_SERVE : S_CLEAR;
            S_CLEAR: begin
                if (pend_vld) begin
                    launch = 1'b1;
                    l_op   = OP_HOST;
                    l_cmd  = '{we: pend_we, addr: pend_addr, din: pend_din};
                end else if (ptr == fill_limit) begin
                    state_nxt = S_SERVE;
                end else begin
                    launch = 1'b1;
                    l_op   = OP_FILL;
                    l_cmd  = '{we: 1'b1, addr: ptr[ADDR_W-1:0], din: 16'h0};
                end
            end
            S_SERVE: begin
                if (pend_vld) begin
                    launch = 1'b1;
                    l_op   = OP_HOST;
                    l_cmd  = '{we: pend_we, addr: pend_addr, din: pend_din};
                end
            end
            default: state_nxt = S_WAIT_INIT;
        endcase
        if (launch) begin
            state_nxt = S_ISSUE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_WAIT_INIT;
            op        <= OP_W2;
            cmd_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            match     <= '0;
            ptr       <= '0;
            cfg       <= '0;
            busy      <= 1'b1;
            host_ack  <= 1'b0;
            host_dout <= '0;
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_din  <= '0;
        end else begin
            state    <= state_nxt;
            host_ack <= 1'b0;

            if (launch) begin
                op       <= l_op;
                cmd_we   <= l_cmd.we;
                mem_addr <= l_cmd.addr;
                mem_din  <= l_cmd.din;
                if (l_op == OP_HOST) begin
                    pend_vld <= 1'b0;
                end
            end

            if (state == S_WAIT && mem_ready) begin
                case (op)
                    OP_R2:   match[2] <= (mem_dout == SIG2);
                    OP_R1:   match[1] <= (mem_dout == SIG1);
                    OP_R0:   match[0] <= (mem_dout == SIG0);
                    OP_FILL: ptr <= ptr + 28'd2;
                    OP_HOST: begin
                        host_ack <= 1'b1;
                        if (!cmd_we) begin
                            host_dout <= mem_dout;
                        end
                    end
                    default: ;
                endcase
            end

            // Larger sizes only count if the base location itself read back correctly.
            if (state == S_DECIDE) begin
                cfg <= {1'b1, ~match[0], 11'd0,
                        match[2] & match[0], match[1] & match[0], match[0]};
            end

            if (state_nxt == S_SERVE) begin
                busy <= 1'b0;
            end

            // A request arriving as the slot is being issued takes the freed slot.
            if (host_req && (!pend_vld || (launch && l_op == OP_HOST))) begin
                pend_vld  <= 1'b1;
                pend_we   <= host_we;
                pend_addr <= host_addr;
                pend_din  <= host_din;
            end
        end
    end

endmodule

// File: tb/tb_sdram_probe_seq.sv
// Bench for sdram_probe_seq: aliasing SDRAM model with random latency and a command log.
module tb_sdram_probe_seq;

    localparam int          AW   = 27;
    localparam logic [15:0] SIG0 = 16'd1032;
    localparam logic [15:0] SIG1 = 16'd2064;
    localparam logic [15:0] SIG2 = 16'd3128;
    localparam logic [15:0] SIGA = 16'd12345;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout = 16'h0;
    logic          mem_we, mem_rd;
    logic [AW-1:0] host_addr = '0;
    logic [15:0]   host_din = 16'h0;
    logic          host_we = 1'b0;
    logic          host_req = 1'b0;
    logic          host_ack;
    logic [15:0]   host_dout, cfg;
    logic          busy;

    sdram_probe_seq dut (
        .clk(clk), .reset(reset), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we), .mem_rd(mem_rd),
        .host_addr(host_addr), .host_din(host_din), .host_we(host_we),
        .host_req(host_req), .host_ack(host_ack), .host_dout(host_dout),
        .cfg(cfg), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        int          addr;
        logic [15:0] din;
    } ent_t;

    ent_t          cmd_log[$];
    logic [15:0]   mem[int];
    int            msize = 'h8000000;
    bit            stall = 1'b0;
    int            lat = 0;
    int            key = 0;
    int            prot_err = 0;
    int            ack_cnt = 0;
    logic [15:0]   rd_val = 16'h0;
    logic [AW-1:0] cur_addr = '0;
    logic [15:0]   cur_din = 16'h0;
    int            checks = 0;
    int            errors = 0;

    // SDRAM model: addresses alias modulo msize; ready drops for a random time after each strobe.
    always @(negedge clk) begin
        if (reset) begin
            mem_ready = 1'b1;
            lat = 0;
        end else if (mem_we || mem_rd) begin
            if (!mem_ready || (mem_we && mem_rd)) prot_err++;
            key = int'(mem_addr) % msize;
            cmd_log.push_back('{we: mem_we, addr: int'(mem_addr), din: mem_din});
            if (mem_we) mem[key] = mem_din;
            else rd_val = mem.exists(key) ? mem[key] : 16'h0;
            cur_addr  = mem_addr;
            cur_din   = mem_din;
            lat       = 1 + int'($urandom % 4);
            mem_ready = 1'b0;
            mem_dout  = 16'($urandom);
        end else if (!mem_ready) begin
            if (mem_addr !== cur_addr || mem_din !== cur_din) prot_err++;
            if (lat > 0) lat--;
            if (lat == 0 && !stall) begin
                mem_ready = 1'b1;
                mem_dout  = rd_val;
            end
        end
    end

    always @(negedge clk) if (host_ack === 1'b1) ack_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ent_key(input ent_t e);
        return {19'd0, e.we, e.addr[27:0], e.we ? e.din : 16'h0};
    endfunction

    // Expected cfg: replay the probe writes into an aliasing memory and apply the sizing rules.
    function automatic logic [15:0] ref_cfg(input int size);
        int          wa[4] = '{'h4000000, 'h2000000, 0, 'h1000000};
        logic [15:0] wd[4] = '{SIG2, SIG1, SIG0, SIGA};
        int          ra[3] = '{0, 'h2000000, 'h4000000};
        logic [15:0] rs[3] = '{SIG0, SIG1, SIG2};
        bit          ok[3];
        logic [15:0] v;
        for (int r = 0; r < 3; r++) begin
            v = 16'h0;
            for (int w = 0; w < 4; w++) if (wa[w] % size == ra[r] % size) v = wd[w];
            ok[r] = (v == rs[r]);
        end
        if (!ok[0]) return 16'hC000;
        return {1'b1, 1'b0, 11'd0, ok[2], ok[1], 1'b1};
    endfunction

    task automatic wait_log(input int n, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (cmd_log.size() >= n) begin ok = 1'b1; break; end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (cfg[15] === 1'b1) begin ok = 1'b1; break; end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_ack(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (host_ack === 1'b1) begin ok = 1'b1; break; end
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic send_req(input bit we, input int a, input logic [15:0] d);
        @(negedge clk);
        host_we = we; host_addr = AW'(a); host_din = d; host_req = 1'b1;
        @(negedge clk);
        host_req = 1'b0;
    endtask

    task automatic do_reset(input int size);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        msize = size; stall = 1'b0;
        mem.delete(); cmd_log.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_probe(input string tag);
        ent_t exp[7];
        exp[0] = '{1'b1, 'h4000000, SIG2};
        exp[1] = '{1'b1, 'h2000000, SIG1};
        exp[2] = '{1'b1, 0,         SIG0};
        exp[3] = '{1'b1, 'h1000000, SIGA};
        exp[4] = '{1'b0, 'h4000000, 16'h0};
        exp[5] = '{1'b0, 'h2000000, 16'h0};
        exp[6] = '{1'b0, 0,         16'h0};
        chk({tag, "_len"}, 64'(cmd_log.size() >= 7), 64'd1);
        if (cmd_log.size() >= 7)
            for (int i = 0; i < 7; i++)
                chk($sformatf("%s_cmd%0d", tag, i), ent_key(cmd_log[i]), ent_key(exp[i]));
    endtask

    initial begin
        int a0, ptr, nhost, nbad, v;
        bit fill_after;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", 64'(mem_we), 0);
        chk("rst_rd", 64'(mem_rd), 0);
        chk("rst_ack", 64'(host_ack), 0);
        chk("rst_cfg", 64'(cfg), 0);
        chk("rst_busy", 64'(busy), 1);
        chk("rst_addr", 64'(mem_addr), 0);
        chk("rst_din", 64'(mem_din), 0);
        chk("rst_dout", 64'(host_dout), 0);

        // 128MB: reset during the aliasing write's WAIT, then a full rerun
        msize = 'h8000000;
        reset = 1'b0;
        wait_log(4, 300, "wa_issued");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_we", 64'(mem_we), 0);
        chk("midrst_rd", 64'(mem_rd), 0);
        chk("midrst_busy", 64'(busy), 1);
        chk("midrst_cfg", 64'(cfg), 0);
        chk("midrst_addr", 64'(mem_addr), 0);
        chk("midrst_din", 64'(mem_din), 0);
        repeat (2) @(negedge clk);
        mem.delete(); cmd_log.delete();
        @(negedge clk);
        reset = 1'b0;
        wait_done("done_128");
        chk("cfg_128", 64'(cfg), 64'(ref_cfg(msize)));
        chk("cfg_128_const", 64'(cfg), 64'h8007);
        chk("busy_clear", 64'(busy), 1);
        chk_probe("probe_128");

        // Host request during CLEAR while the current fill write is stalled; a second one is dropped
        wait_log(17, 1000, "fill_progress");
        stall = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk); a0 = ack_cnt;
        send_req(1'b1, 'h100, 16'hABCD);
        send_req(1'b1, 'h300, 16'h1111);
        repeat (5) @(negedge clk);
        @(posedge clk);
        chk("ack_held_stall", 64'(ack_cnt - a0), 0);
        stall = 1'b0;
        wait_ack("ack_clear", 200);
        repeat (60) @(negedge clk);
        @(posedge clk);
        chk("ack_count_clear", 64'(ack_cnt - a0), 1);
        ptr = 0; nhost = 0; nbad = 0; fill_after = 1'b0;
        for (int i = 7; i < cmd_log.size(); i++) begin
            if (cmd_log[i].we && cmd_log[i].addr == 'h100 && cmd_log[i].din == 16'hABCD) nhost++;
            else if (cmd_log[i].we && cmd_log[i].din == 16'h0 && cmd_log[i].addr == ptr) begin
                ptr += 2;
                if (nhost > 0) fill_after = 1'b1;
            end else nbad++;
        end
        chk("host_in_clear", 64'(nhost), 1);
        chk("fill_seq_bad", 64'(nbad), 0);
        chk("fill_resumed", 64'(fill_after), 1);
        chk("mem_100", 64'(mem.exists('h100) ? mem['h100] : 16'h0), 64'hABCD);

        // 64MB and 32MB sizing, fill starts at 0
        do_reset('h4000000);
        wait_done("done_64");
        chk("cfg_64", 64'(cfg), 64'(ref_cfg(msize)));
        wait_log(9, 200, "fill_64");
        chk("fill64_0", ent_key(cmd_log[7]), {19'd0, 1'b1, 28'h0, 16'h0});
        chk("fill64_1", ent_key(cmd_log[8]), {19'd0, 1'b1, 28'h2, 16'h0});

        do_reset('h2000000);
        wait_done("done_32");
        chk("cfg_32", 64'(cfg), 64'(ref_cfg(msize)));
        chk("cfg_32_const", 64'(cfg), 64'h8001);
        chk_probe("probe_32");

        // 16MB: fault, straight to SERVE, host traffic
        do_reset('h1000000);
        wait_done("done_16");
        chk("cfg_16", 64'(cfg), 64'(ref_cfg(msize)));
        chk("cfg_16_const", 64'(cfg), 64'hC000);
        repeat (30) @(negedge clk);
        chk("busy_serve", 64'(busy), 0);
        @(posedge clk);
        chk("no_fill_16", 64'(cmd_log.size()), 7);

        send_req(1'b1, 'h100, 16'hABCD);
        wait_ack("ack_w100", 100);
        chk("dout_after_write", 64'(host_dout), 0);
        send_req(1'b0, 'h100, 16'h0);
        wait_ack("ack_r100", 100);
        chk("dout_r100", 64'(host_dout), 64'hABCD);

        v = int'($urandom_range(1, 16'hFFFE));
        send_req(1'b1, 'h200, 16'(v));
        wait_ack("ack_w200", 100);
        stall = 1'b1;
        @(posedge clk); a0 = ack_cnt;
        send_req(1'b0, 'h200, 16'h0);
        repeat (20) @(negedge clk);
        @(posedge clk);
        chk("ack_waits_ready", 64'(ack_cnt - a0), 0);
        stall = 1'b0;
        wait_ack("ack_r200", 100);
        chk("dout_r200", 64'(host_dout), 64'(16'(v)));

        // New request landing on the same cycle as an ack
        send_req(1'b0, 'h100, 16'h0);
        wait_ack("ack_r100b", 100);
        host_we = 1'b1; host_addr = AW'('h180); host_din = 16'h5A5A; host_req = 1'b1;
        chk("dout_r100b", 64'(host_dout), 64'hABCD);
        @(negedge clk);
        host_req = 1'b0;
        wait_ack("ack_overlap", 100);
        send_req(1'b0, 'h180, 16'h0);
        wait_ack("ack_r180", 100);
        chk("dout_r180", 64'(host_dout), 64'h5A5A);

        @(posedge clk);
        chk("protocol_errors", 64'(prot_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
